// File: rtl/decimal_entry_accum.sv
// decimal_entry_accum: keypad-style decimal entry accumulator with range-clamped commit.
// Optional BCD echo of entered digits is built when DECIMAL_ENTRY_ECHO_EN is defined.
module decimal_entry_accum #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                digit_valid,
  input  logic [3:0]          digit,
  input  logic                backspace,
  input  logic                clear,
  input  logic                commit,
  input  logic [W-1:0]        min_val,
  input  logic [W-1:0]        max_val,
  output logic                in_ready,
  output logic [W-1:0]        value,
  output logic [2:0]          digit_count,
  output logic                commit_valid,
  output logic [W-1:0]        commit_value,
  output logic                error,
  output logic [4*DIGITS-1:0] echo_digits
);

  localparam int unsigned EW = W + 4;
  localparam int unsigned CW = $clog2(W) + 1;
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [0:0] {IDLE, DIV} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  value_d, commit_value_d;
  logic [2:0]    count_d;
  logic          commit_valid_d, error_d;
  logic [W-1:0]  work_q, work_d;
  logic [3:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [EW-1:0] prod;
  logic [4:0]    rem_sh;
  logic          qbit;
  logic [W-1:0]  quot;
  logic [W-1:0]  clamped;
  logic          digit_ok;

`ifdef DECIMAL_ENTRY_ECHO_EN
  logic [BW-1:0] echo_q, echo_d;
  assign echo_digits = echo_q;
`else
  assign echo_digits = '0;
`endif

  // Candidate value after appending a digit, wide enough to never overflow
  assign prod     = EW'(value) * EW'(10) + EW'(digit);
  assign digit_ok = (digit <= 4'd9) && (digit_count < 3'(DIGITS)) && (prod <= EW'(max_val));

  // One restoring-division step by ten: quotient bits shift into work from the right
  assign rem_sh = {rem_q, work_q[W-1]};
  assign qbit   = (rem_sh >= 5'd10);
  assign quot   = (work_q << 1) | W'(qbit);

  always_comb begin
    clamped = value;
    if (value < min_val)      clamped = min_val;
    else if (value > max_val) clamped = max_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    value_d        = value;
    count_d        = digit_count;
    commit_valid_d = 1'b0;
    commit_value_d = commit_value;
    error_d        = 1'b0;
    work_d         = work_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
`ifdef DECIMAL_ENTRY_ECHO_EN
    echo_d         = echo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          value_d = '0;
          count_d = '0;
`ifdef DECIMAL_ENTRY_ECHO_EN
          echo_d  = '0;
`endif
        end else if (commit) begin
          commit_value_d = clamped;
          commit_valid_d = 1'b1;
          value_d        = '0;
          count_d        = '0;
`ifdef DECIMAL_ENTRY_ECHO_EN
          echo_d         = '0;
`endif
        end else if (backspace) begin
          if (digit_count == 3'd0) begin
            error_d = 1'b1;
          end else begin
            work_d  = value;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end else if (digit_valid) begin
          if (digit_ok) begin
            value_d = W'(prod);
            count_d = digit_count + 3'd1;
`ifdef DECIMAL_ENTRY_ECHO_EN
            echo_d  = (echo_q << 4) | BW'(digit);
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
      DIV: begin
        work_d = quot;
        rem_d  = qbit ? 4'(rem_sh - 5'd10) : rem_sh[3:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          value_d = quot;
          count_d = digit_count - 3'd1;
          state_d = IDLE;
`ifdef DECIMAL_ENTRY_ECHO_EN
          echo_d  = echo_q >> 4;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready     <= 1'b1;
      value        <= '0;
      digit_count  <= '0;
      commit_valid <= 1'b0;
      commit_value <= '0;
      error        <= 1'b0;
      work_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
`ifdef DECIMAL_ENTRY_ECHO_EN
      echo_q       <= '0;
`endif
    end else begin
      in_ready     <= (state_d == IDLE);
      value        <= value_d;
      digit_count  <= count_d;
      commit_valid <= commit_valid_d;
      commit_value <= commit_value_d;
      error        <= error_d;
      work_q       <= work_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
`ifdef DECIMAL_ENTRY_ECHO_EN
      echo_q       <= echo_d;
`endif
    end
  end

endmodule

// File: tb/tb_decimal_entry_accum.sv
// Bench for decimal_entry_accum: directed scenarios then random requests against a digit-list model.
module tb_decimal_entry_accum;
  localparam int W = 8;
  localparam int DIGITS = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                digit_valid, backspace, clear, commit;
  logic [3:0]          digit;
  logic [W-1:0]        min_val, max_val;
  logic                in_ready, commit_valid, error;
  logic [W-1:0]        value, commit_value;
  logic [2:0]          digit_count;
  logic [4*DIGITS-1:0] echo_digits;

  decimal_entry_accum #(.W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .digit_valid(digit_valid), .digit(digit),
    .backspace(backspace), .clear(clear), .commit(commit),
    .min_val(min_val), .max_val(max_val), .in_ready(in_ready), .value(value),
    .digit_count(digit_count), .commit_valid(commit_valid), .commit_value(commit_value),
    .error(error), .echo_digits(echo_digits)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the entered digits in order, plus pending-backspace latency
  int q[$];
  int busy = 0;
  bit exp_err = 0, exp_cv = 0, exp_ready = 1;
  int exp_cvv = 0;

  function automatic int qval();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic logic [31:0] qecho();
    logic [31:0] e = 0;
`ifdef DECIMAL_ENTRY_ECHO_EN
    foreach (q[i]) e = (e << 4) | 32'(q[i]);
`endif
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    busy = 0; exp_err = 0; exp_cv = 0; exp_ready = 1; exp_cvv = 0;
  endtask

  task automatic model_edge();
    int v, mn, mx, dg;
    exp_err = 0; exp_cv = 0;
    v = qval(); mn = int'(min_val); mx = int'(max_val); dg = int'(digit);
    if (busy > 0) begin
      busy--;
      if (busy == 0) void'(q.pop_back());
    end else if (clear) begin
      q.delete();
    end else if (commit) begin
      exp_cvv = (v < mn) ? mn : (v > mx) ? mx : v;
      exp_cv = 1;
      q.delete();
    end else if (backspace) begin
      if (q.size() == 0) exp_err = 1;
      else busy = W;
    end else if (digit_valid) begin
      if (dg > 9 || q.size() == DIGITS || v * 10 + dg > mx) exp_err = 1;
      else q.push_back(dg);
    end
    exp_ready = (busy == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("value", 32'(value), 32'(qval()));
    chk("digit_count", 32'(digit_count), 32'(q.size()));
    chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
    chk("commit_value", 32'(commit_value), 32'(exp_cvv));
    chk("error", 32'(error), 32'(exp_err));
    chk("echo_digits", 32'(echo_digits), qecho());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic req(input bit v, input logic [3:0] d, input bit b, input bit c, input bit m);
    digit_valid = v; digit = d; backspace = b; clear = c; commit = m;
    tick();
    digit_valid = 0; backspace = 0; clear = 0; commit = 0;
  endtask

  initial begin
    reset_n = 0; digit_valid = 0; digit = 0; backspace = 0; clear = 0; commit = 0;
    min_val = 8'd1; max_val = 8'd99;
    model_reset();
    #12;
    check_all();
    reset_n = 1;

    // Basic entry and commit
    req(1, 4'd2, 0, 0, 0);
    req(1, 4'd1, 0, 0, 0);
    chk("entry_21", 32'(value), 32'd21);
    chk("entry_21_count", 32'(digit_count), 32'd2);
    req(0, 4'd0, 0, 0, 1);
    chk("commit_21", 32'(commit_value), 32'd21);
    chk("commit_21_strobe", 32'(commit_valid), 32'd1);
    tick();

    // Digit limit
    req(1, 4'd2, 0, 0, 0);
    req(1, 4'd1, 0, 0, 0);
    req(1, 4'd5, 0, 0, 0);
    chk("overflow_err", 32'(error), 32'd1);
    chk("overflow_value", 32'(value), 32'd21);
    req(0, 4'd0, 0, 1, 0);

    // Range limit and illegal digit
    max_val = 8'd20;
    req(1, 4'd2, 0, 0, 0);
    req(1, 4'd5, 0, 0, 0);
    chk("range_err_value", 32'(value), 32'd2);
    req(1, 4'hA, 0, 0, 0);
    chk("nondecimal_err", 32'(error), 32'd1);
    req(0, 4'd0, 0, 1, 0);
    max_val = 8'd99;

    // Backspace through division, then underflow
    req(1, 4'd2, 0, 0, 0);
    req(1, 4'd1, 0, 0, 0);
    req(0, 4'd0, 1, 0, 0);
    chk("div_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < W; i++) req(1, 4'd7, 0, 0, 0);
    chk("bs_value", 32'(value), 32'd2);
    req(0, 4'd0, 1, 0, 0);
    for (int i = 0; i < W; i++) tick();
    req(0, 4'd0, 1, 0, 0);
    chk("bs_empty_err", 32'(error), 32'd1);

    // Clamp on commit of zero, commit beats digit
    req(0, 4'd0, 0, 0, 1);
    chk("clamp_min", 32'(commit_value), 32'd1);
    req(1, 4'd3, 0, 0, 0);
    req(1, 4'd4, 0, 0, 1);
    tick();
    chk("dropped_digit", 32'(value), 32'd0);

    // Asynchronous reset during the fourth division cycle
    req(1, 4'd2, 0, 0, 0);
    req(1, 4'd1, 0, 0, 0);
    req(0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #3 reset_n = 0;
    model_reset();
    #1;
    check_all();
    #2 reset_n = 1;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        min_val = 8'($urandom_range(0, 20));
        max_val = 8'($urandom_range(20, 120));
      end
      req(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decimal_entry_accum.md
DECIMAL_ENTRY_ACCUM -- requirements
Module: decimal_entry_accum

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning the binary value width.
REQ-002 The module SHALL have parameter DIGITS, default 2, meaning the maximum number of entered decimal digits (1..4).
REQ-003 The module SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The module SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port digit_valid  input  1  digit entry request.
REQ-006 The module SHALL have port digit  input  4  entered decimal digit.
REQ-007 The module SHALL have port backspace  input  1  remove last digit request.
REQ-008 The module SHALL have port clear  input  1  discard entry request.
REQ-009 The module SHALL have port commit  input  1  finish entry request.
REQ-010 The module SHALL have ports min_val and max_val  input  W  each, meaning the inclusive legal range of the value.
REQ-011 The module SHALL have port in_ready  output  1  requests accepted this cycle.
REQ-012 The module SHALL have port value  output  W  current accumulated binary value.
REQ-013 The module SHALL have port digit_count  output  3  digits currently entered.
REQ-014 The module SHALL have port commit_valid  output  1  one-cycle commit strobe.
REQ-015 The module SHALL have port commit_value  output  W  committed value, held until next commit.
REQ-016 The module SHALL have port error  output  1  one-cycle rejected-request strobe.
REQ-017 The module SHALL have port echo_digits  output  4*DIGITS  entered digits as BCD, digit 0 least significant.

Function
REQ-018 Requests SHALL be sampled only when in_ready=1; when in_ready=0 they SHALL be ignored without error.
REQ-019 Simultaneous requests SHALL be resolved with priority clear > commit > backspace > digit_valid; lower-priority requests SHALL be dropped silently.
REQ-020 The FSM SHALL have states IDLE (in_ready=1), DIV (in_ready=0), and no other states.
REQ-021 An accepted digit SHALL update value to value*10+digit and increment digit_count on the same clock edge, using W+4-bit intermediate arithmetic.
REQ-022 A digit > 9, a digit when digit_count==DIGITS, or a digit whose result exceeds max_val SHALL be rejected: error=1 for one cycle, with value and digit_count unchanged.
REQ-023 An accepted backspace with digit_count>0 SHALL enter DIV, compute value/10 by restoring division over exactly W cycles, write the quotient to value, decrement digit_count, and return to IDLE; in_ready SHALL be low for W cycles.
REQ-024 A backspace with digit_count==0 SHALL assert error for one cycle and remain in IDLE.
REQ-025 An accepted commit SHALL load commit_value with value clamped to [min_val,max_val], pulse commit_valid on the next cycle, and zero value and digit_count.
REQ-026 An accepted clear SHALL zero value and digit_count with no strobe.
REQ-027 error and commit_valid SHALL never be high in the same cycle.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, in_ready=1, value=0, digit_count=0, commit_valid=0, commit_value=0, error=0, and echo_digits=0, including during DIV.

Configuration
REQ-029 With macro DECIMAL_ENTRY_ECHO_EN defined, echo_digits SHALL be a shift register: an accepted digit shifts in at digit 0, backspace shifts toward digit 0 with zero fill at completion of DIV, and clear/commit zero it.
REQ-030 Without DECIMAL_ENTRY_ECHO_EN, echo_digits SHALL be tied to 0 and no echo storage SHALL be synthesized.

Verification
REQ-031 W=8, DIGITS=2, min=1, max=99: digits 2 then 1, then commit -> value=21, digit_count=2, then commit_valid pulse with commit_value=21, and value=0 the cycle after.
REQ-032 Digits 2,1,5 -> third digit produces error pulse; value stays 21 and echo_digits=0x21 (ECHO_EN).
REQ-033 max=20: digits 2,5 -> second digit produces error pulse, value=2; digit 0xA produces error.
REQ-034 value=21: backspace -> in_ready low for 8 cycles, then value=2 and digit_count=1; a further two backspaces -> value=0, then error.
REQ-035 value=0, min=1: commit -> commit_value=1; commit+digit in the same cycle -> digit dropped.
REQ-036 Assert reset_n during the 4th DIV cycle -> all outputs at reset values immediately, in_ready=1.
